// File: rtl/mt9v034_pkg.sv
// Shared types and constants for the MT9V034 stream framer.
// Default field positions describe the reversed 12-bit LVDS word.
package mt9v034_pkg;

  typedef enum logic [2:0] {INIT, SYNC, IDLE, FRAME, LINE} state_e;

  localparam int unsigned ERR_OVF    = 0;
  localparam int unsigned ERR_LEN    = 1;
  localparam int unsigned ERR_LVNOFV = 2;

  localparam int unsigned DEF_WORD_W     = 12;
  localparam int unsigned DEF_PIX_W      = 8;
  localparam int unsigned DEF_PIX_LSB    = 1;
  localparam int unsigned DEF_LV_BIT     = 9;
  localparam int unsigned DEF_FV_BIT     = 10;
  localparam int unsigned DEF_CNT_W      = 11;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/px_stream_fifo.sv
// Synchronous FIFO with a registered output stage; the output register counts toward DEPTH,
// so at most DEPTH entries are ever accepted while the reader stalls.
module px_stream_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d, stored;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             do_wr, do_pop, do_load;

  assign full    = (count_q == FullLvl);
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en && !full;
  assign do_pop  = out_valid_q && rd_ready;
  // Entries still in memory, i.e. not yet moved into the output register.
  assign stored  = count_q - {{AW{1'b0}}, out_valid_q};
  assign do_load = (stored != '0) && (!out_valid_q || rd_ready);

  assign rd_valid = out_valid_q;
  assign rd_data  = out_data_q;

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_wr && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_load) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        out_data_q  <= mem[rd_ptr_q];
        out_valid_q <= 1'b1;
      end else if (do_pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mt9v034_stream_framer.sv
// MT9V034 raw-word to AXI4-Stream framer with line/frame tracking and sticky errors.
// Optional MT9V034_TEST_PATTERN_EN adds tp_en, replacing pixels by (col + row).
module mt9v034_stream_framer
  import mt9v034_pkg::*;
#(
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter bit          REVERSE    = 1'b1,
  parameter int unsigned PIX_W      = DEF_PIX_W,
  parameter int unsigned PIX_LSB    = DEF_PIX_LSB,
  parameter int unsigned LV_BIT     = DEF_LV_BIT,
  parameter int unsigned FV_BIT     = DEF_FV_BIT,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              pxclk,
  input  logic              pxrst_n,
  input  logic              rx_locked,
  input  logic              rx_valid,
  input  logic [WORD_W-1:0] rx_data,
  output logic [PIX_W-1:0]  m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic [CNT_W-1:0]  line_len,
  output logic [CNT_W-1:0]  frame_rows,
  output logic              frame_done,
  output logic [2:0]        err_sticky,
  input  logic              err_clr
`ifdef MT9V034_TEST_PATTERN_EN
  ,
  input  logic              tp_en
`endif
);

  logic [WORD_W-1:0] word;
  logic [PIX_W-1:0]  pix, pix_first, pix_next;
  logic              lv, fv;

  for (genvar i = 0; i < WORD_W; i++) begin : g_rev
    assign word[i] = REVERSE ? rx_data[WORD_W-1-i] : rx_data[i];
  end

  assign pix = word[PIX_LSB +: PIX_W];
  assign lv  = word[LV_BIT];
  assign fv  = word[FV_BIT];

  state_e           state_q, state_d;
  logic             sof_q, sof_d, drop_q, drop_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d, first_len_q, first_len_d;
  logic [CNT_W-1:0] col_inc, row_inc;
  logic             hold_v_q, hold_v_d, hold_sof_q, hold_sof_d;
  logic [PIX_W-1:0] hold_pix_q, hold_pix_d;
  logic [CNT_W-1:0] line_len_q, line_len_d, frame_rows_q, frame_rows_d;
  logic             frame_done_q, frame_done_d;
  logic [2:0]       err_q, err_d, err_set;
  logic             push, push_last, fifo_wr, fifo_full, fifo_empty;
  logic [PIX_W+1:0] fifo_rd;

  assign col_inc = (&col_q) ? col_q : col_q + 1'b1;
  assign row_inc = (&row_q) ? row_q : row_q + 1'b1;

`ifdef MT9V034_TEST_PATTERN_EN
  // row_q is zero whenever a frame starts, so the first pixel of line 0 reads 0.
  assign pix_first = tp_en ? PIX_W'(row_q) : pix;
  assign pix_next  = tp_en ? PIX_W'(col_inc + row_q) : pix;
`else
  assign pix_first = pix;
  assign pix_next  = pix;
`endif

  always_comb begin
    state_d      = state_q;
    sof_d        = sof_q;
    drop_d       = drop_q;
    col_d        = col_q;
    row_d        = row_q;
    first_len_d  = first_len_q;
    hold_v_d     = hold_v_q;
    hold_sof_d   = hold_sof_q;
    hold_pix_d   = hold_pix_q;
    line_len_d   = line_len_q;
    frame_rows_d = frame_rows_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    push_last    = 1'b0;
    err_set      = '0;
    if (!rx_locked) begin
      state_d  = INIT;
      hold_v_d = 1'b0;
      row_d    = '0;
    end else begin
      unique case (state_q)
        INIT: state_d = SYNC;
        SYNC: if (rx_valid && !fv && !lv) state_d = IDLE;
        IDLE: begin
          if (rx_valid && fv) begin
            sof_d  = 1'b1;
            drop_d = 1'b0;
            row_d  = '0;
            col_d  = '0;
            if (lv) begin
              state_d    = LINE;
              hold_v_d   = 1'b1;
              hold_pix_d = pix_first;
              hold_sof_d = 1'b1;
              sof_d      = 1'b0;
            end else begin
              state_d = FRAME;
            end
          end
        end
        FRAME: begin
          if (rx_valid && fv && lv) begin
            state_d    = LINE;
            col_d      = '0;
            hold_v_d   = 1'b1;
            hold_pix_d = pix_first;
            hold_sof_d = sof_q;
            sof_d      = 1'b0;
          end else if (rx_valid && !fv && !lv) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            frame_rows_d = row_q;
            row_d        = '0;
          end
        end
        LINE: begin
          if (rx_valid && fv && lv) begin
            push       = hold_v_q;
            col_d      = col_inc;
            hold_v_d   = 1'b1;
            hold_pix_d = pix_next;
            hold_sof_d = sof_q;
            sof_d      = 1'b0;
          end else if (rx_valid && !lv) begin
            push       = hold_v_q;
            push_last  = 1'b1;
            hold_v_d   = 1'b0;
            line_len_d = col_inc;
            row_d      = row_inc;
            if (row_q == '0) begin
              first_len_d = col_inc;
            end else if (col_inc != first_len_q) begin
              err_set[ERR_LEN] = 1'b1;
            end
            if (fv) begin
              state_d = FRAME;
            end else begin
              state_d      = IDLE;
              frame_done_d = 1'b1;
              frame_rows_d = row_inc;
              row_d        = '0;
            end
          end
        end
        default: state_d = INIT;
      endcase
      if (rx_valid && lv && !fv && state_q != INIT) begin
        err_set[ERR_LVNOFV] = 1'b1;
      end
    end
    // Once a pixel is lost the rest of the frame is discarded until the next SOF.
    if (push && !drop_q && fifo_full) begin
      err_set[ERR_OVF] = 1'b1;
      drop_d           = 1'b1;
    end
    err_d = err_clr ? '0 : (err_q | err_set);
  end

  assign fifo_wr = push && !drop_q && !fifo_full;

  always_ff @(posedge pxclk or negedge pxrst_n) begin
    if (!pxrst_n) begin
      state_q      <= INIT;
      sof_q        <= 1'b0;
      drop_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      first_len_q  <= '0;
      hold_v_q     <= 1'b0;
      hold_sof_q   <= 1'b0;
      hold_pix_q   <= '0;
      line_len_q   <= '0;
      frame_rows_q <= '0;
      frame_done_q <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      sof_q        <= sof_d;
      drop_q       <= drop_d;
      col_q        <= col_d;
      row_q        <= row_d;
      first_len_q  <= first_len_d;
      hold_v_q     <= hold_v_d;
      hold_sof_q   <= hold_sof_d;
      hold_pix_q   <= hold_pix_d;
      line_len_q   <= line_len_d;
      frame_rows_q <= frame_rows_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  px_stream_fifo #(
    .WIDTH (PIX_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (pxclk),
    .rst_n    (pxrst_n),
    .wr_en    (fifo_wr),
    .wr_data  ({hold_sof_q, push_last, hold_pix_q}),
    .rd_ready (m_tready),
    .rd_valid (m_tvalid),
    .rd_data  (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {m_tuser, m_tlast, m_tdata} = fifo_rd;
  assign line_len   = line_len_q;
  assign frame_rows = frame_rows_q;
  assign frame_done = frame_done_q;
  assign err_sticky = err_q;

  logic unused_bits;
  assign unused_bits = ^{word, fifo_empty};

endmodule

// File: tb/tb_mt9v034_stream_framer.sv
// Directed bench for mt9v034_stream_framer: framing, sync, length errors, overflow, stalls, relock.
module tb_mt9v034_stream_framer;

  logic        clk = 1'b0;
  logic        rst_n, rx_locked, rx_valid, err_clr;
  logic [11:0] rx_data;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tuser, m_tlast, frame_done;
  logic [10:0] line_len, frame_rows;
  logic [2:0]  err_sticky;

  int          total = 0;
  int          bad = 0;
  int          fd_cnt = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  got_q[$];
  bit          rand_rdy = 1'b0;
  bit          rdy_fixed = 1'b1;
  bit          prev_stall = 1'b0;
  logic [9:0]  prev_beat = '0;

  always #5 clk = ~clk;

  mt9v034_stream_framer dut (
    .pxclk      (clk),
    .pxrst_n    (rst_n),
    .rx_locked  (rx_locked),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .line_len   (line_len),
    .frame_rows (frame_rows),
    .frame_done (frame_done),
    .err_sticky (err_sticky),
`ifdef MT9V034_TEST_PATTERN_EN
    .tp_en      (1'b0),
`endif
    .err_clr    (err_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Raw word: fv/lv/pixel placed at the default positions, then bit-reversed as on the wire.
  function automatic logic [11:0] mk(input bit fv, input bit lv, input logic [7:0] px);
    logic [11:0] w;
    logic [11:0] r;
    w = '0;
    w[8:1] = px;
    w[9] = lv;
    w[10] = fv;
    for (int i = 0; i < 12; i++) r[i] = w[11-i];
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One valid word followed by one junk word with rx_valid low.
  task automatic send(input bit fv, input bit lv, input logic [7:0] px);
    rx_data = mk(fv, lv, px);
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data = 12'($urandom());
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int nlines, input int len0, input int len_last,
                            input logic [7:0] base, input bit exp_on, input bit joint_end);
    int len;
    logic [7:0] px;
    send(1'b0, 1'b0, 8'h00);
    send(1'b1, 1'b0, 8'h00);
    for (int l = 0; l < nlines; l++) begin
      len = (l == nlines - 1) ? len_last : len0;
      for (int p = 0; p < len; p++) begin
        px = base + 8'(l * 32 + p);
        send(1'b1, 1'b1, px);
        if (exp_on) exp_q.push_back({(l == 0 && p == 0), (p == len - 1), px});
      end
      if (!(joint_end && l == nlines - 1)) send(1'b1, 1'b0, 8'h00);
    end
    send(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_beats(input string tag);
    int waited;
    waited = 0;
    while (got_q.size() < exp_q.size() && waited < 600) begin
      @(posedge clk);
      waited++;
    end
    idle(24);
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check_eq("stall_valid", 32'(m_tvalid), 32'd1);
        check_eq("stall_beat", 32'({m_tuser, m_tlast, m_tdata}), 32'(prev_beat));
      end
      if (m_tvalid && m_tready) got_q.push_back({m_tuser, m_tlast, m_tdata});
      if (frame_done) fd_cnt++;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tuser, m_tlast, m_tdata};
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_locked = 1'b0; rx_valid = 1'b0; rx_data = '0; err_clr = 1'b0;
    idle(3);
    check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_beat", 32'({m_tuser, m_tlast, m_tdata}), 32'd0);
    check_eq("rst_line_len", 32'(line_len), 32'd0);
    check_eq("rst_frame_rows", 32'(frame_rows), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_err", 32'(err_sticky), 32'd0);
    rst_n = 1'b1;
    idle(1);
    rx_locked = 1'b1;
    idle(2);

    // Basic 3x4 frame.
    fd_cnt = 0;
    send_frame(3, 4, 4, 8'h10, 1'b1, 1'b0);
    check_beats("basic");
    check_eq("basic_line_len", 32'(line_len), 32'd4);
    check_eq("basic_frame_rows", 32'(frame_rows), 32'd3);
    check_eq("basic_frame_done", 32'(fd_cnt), 32'd1);
    check_eq("basic_err", 32'(err_sticky), 32'd0);

    // Lock obtained mid-frame: nothing until a fresh frame starts.
    rx_locked = 1'b0;
    idle(2);
    rx_locked = 1'b1;
    fd_cnt = 0;
    send(1'b1, 1'b1, 8'hA0);
    send(1'b1, 1'b1, 8'hA1);
    send(1'b1, 1'b0, 8'h00);
    send(1'b1, 1'b1, 8'hA2);
    send(1'b1, 1'b0, 8'h00);
    send_frame(3, 4, 4, 8'h40, 1'b1, 1'b0);
    check_beats("midframe");
    check_eq("midframe_frame_done", 32'(fd_cnt), 32'd1);

    // Lines 4,4,5 with FV and LV falling together on the last line.
    send_frame(3, 4, 5, 8'h60, 1'b1, 1'b1);
    check_beats("lenerr");
    check_eq("lenerr_err", 32'(err_sticky), 32'b010);
    check_eq("lenerr_line_len", 32'(line_len), 32'd5);
    check_eq("lenerr_frame_rows", 32'(frame_rows), 32'd3);
    pulse_clr();
    check_eq("lenerr_clr", 32'(err_sticky), 32'd0);

    // LV without FV is flagged and ignored.
    send(1'b0, 1'b1, 8'h77);
    idle(4);
    check_eq("lvnofv_err", 32'(err_sticky), 32'b100);
    check_beats("lvnofv");
    pulse_clr();
    check_eq("lvnofv_clr", 32'(err_sticky), 32'd0);

    // Overflow: 20-pixel line into a stalled 16-deep FIFO.
    rdy_fixed = 1'b0;
    idle(3);
    send_frame(1, 20, 20, 8'h00, 1'b0, 1'b0);
    check_eq("ovf_err", 32'(err_sticky), 32'b001);
    check_eq("ovf_line_len", 32'(line_len), 32'd20);
    check_eq("ovf_frame_rows", 32'(frame_rows), 32'd1);
    for (int p = 0; p < 16; p++) exp_q.push_back({(p == 0), 1'b0, 8'(p)});
    rdy_fixed = 1'b1;
    send_frame(3, 4, 4, 8'h80, 1'b1, 1'b0);
    check_beats("ovf");
    check_eq("ovf_err_sticky", 32'(err_sticky), 32'b001);
    pulse_clr();

    // Random backpressure: same beats, stall stability checked by the monitor.
    rand_rdy = 1'b1;
    send_frame(3, 4, 4, 8'hC0, 1'b1, 1'b0);
    check_beats("rand");
    rand_rdy = 1'b0;
    idle(2);

    // Lock lost mid-line: the held pixel is dropped, output resumes at a full frame.
    fd_cnt = 0;
    send(1'b0, 1'b0, 8'h00);
    send(1'b1, 1'b0, 8'h00);
    for (int p = 0; p < 4; p++) begin
      send(1'b1, 1'b1, 8'hE0 + 8'(p));
      exp_q.push_back({(p == 0), (p == 3), 8'hE0 + 8'(p)});
    end
    send(1'b1, 1'b0, 8'h00);
    send(1'b1, 1'b1, 8'hE4);
    exp_q.push_back({1'b0, 1'b0, 8'hE4});
    send(1'b1, 1'b1, 8'hE5);
    rx_locked = 1'b0;
    send(1'b1, 1'b1, 8'hE6);
    send(1'b1, 1'b0, 8'h00);
    rx_locked = 1'b1;
    send(1'b1, 1'b1, 8'hE8);
    send(1'b1, 1'b0, 8'h00);
    send_frame(3, 4, 4, 8'h20, 1'b1, 1'b0);
    check_beats("relock");
    check_eq("relock_frame_done", 32'(fd_cnt), 32'd1);
    check_eq("relock_frame_rows", 32'(frame_rows), 32'd3);
    check_eq("relock_err", 32'(err_sticky), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
